// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: MAR/MDR registers, word RAM and a fixed-latency request FSM.
// Optional access-control-violation checking is enabled with `define LC3_MEM_ACV_EN.
module lc3_mem_responder #(
    parameter int DEPTH_LOG2 = 16,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        mem_en,
    input  logic        r_w,
`ifdef LC3_MEM_ACV_EN
    input  logic        priv,
    output logic        mem_acv,
`endif
    input  logic [15:0] from_bus,
    output logic [15:0] mar_out,
    output logic [15:0] mdr_out,
    output logic        mem_r
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("lc3_mem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic [15:0]       r_mar;
    logic [15:0]       r_mdr;
    logic [15:0]       r_req_addr;
    logic [15:0]       r_req_data;
    logic              r_req_rw;
    logic              r_req_viol;
    logic [15:0]       r_rd_q;
    logic [15:0]       r_mem [0:(1 << DEPTH_LOG2) - 1];

    logic              w_accept;
    logic              w_viol;
    logic              w_to_ready;
    logic [15:0]       w_rd_addr;
    logic              w_rd_viol;

    assign w_accept = (r_state == IDLE) && mem_en;

`ifdef LC3_MEM_ACV_EN
    assign w_viol  = priv && ((r_mar < 16'h3000) || (r_mar >= 16'hFE00));
    assign mem_acv = (r_state == READY) && r_req_viol;
`else
    assign w_viol  = 1'b0;
`endif

    // With LATENCY==1 the read happens on the accepting edge, so the address
    // comes straight from MAR rather than the not-yet-latched request copy.
    assign w_to_ready = (w_next == READY) && (r_state != READY);
    assign w_rd_addr  = (r_state == IDLE) ? r_mar  : r_req_addr;
    assign w_rd_viol  = (r_state == IDLE) ? w_viol : r_req_viol;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (mem_en) begin
                    if (LATENCY == 1) begin
                        w_next = READY;
                    end else begin
                        w_next     = BUSY;
                        w_cnt_next = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_next     = READY;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            READY:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_mar      <= 16'h0000;
            r_mdr      <= 16'h0000;
            r_req_addr <= 16'h0000;
            r_req_data <= 16'h0000;
            r_req_rw   <= 1'b0;
            r_req_viol <= 1'b0;
            r_rd_q     <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (ld_mar) begin
                r_mar <= from_bus;
            end
            if (ld_mdr) begin
                r_mdr <= mio_en ? r_rd_q : from_bus;
            end
            if (w_accept) begin
                r_req_addr <= r_mar;
                r_req_data <= r_mdr;
                r_req_rw   <= r_w;
                r_req_viol <= w_viol;
            end
            if (w_to_ready) begin
                r_rd_q <= w_rd_viol ? 16'h0000 : r_mem[w_rd_addr[DEPTH_LOG2-1:0]];
            end
        end
    end

    // Writes commit at the end of the READY cycle; reset forces IDLE first,
    // so an interrupted write never reaches the array.
    always_ff @(posedge clk) begin
        if (r_state == READY && r_req_rw && !r_req_viol) begin
            r_mem[r_req_addr[DEPTH_LOG2-1:0]] <= r_req_data;
        end
    end

    assign mar_out = r_mar;
    assign mdr_out = r_mdr;
    assign mem_r   = (r_state == READY);

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder (LATENCY=3 main instance, LATENCY=1 companion).
module tb_lc3_mem_responder;

    logic        clk;
    logic        reset;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        mem_en;
    logic        r_w;
    logic [15:0] from_bus;
    logic [15:0] mar_out;
    logic [15:0] mdr_out;
    logic        mem_r;
    logic [15:0] d1_mar_out;
    logic [15:0] d1_mdr_out;
    logic        d1_mem_r;
`ifdef LC3_MEM_ACV_EN
    logic        priv;
    logic        mem_acv;
    logic        d1_mem_acv;
`endif

    int          n_checks;
    int          n_errors;
    logic [15:0] model [logic [15:0]];
    logic [15:0] sb [$];

    lc3_mem_responder #(.DEPTH_LOG2(16), .LATENCY(3)) dut (
        .clk(clk), .reset(reset), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .mem_en(mem_en), .r_w(r_w),
`ifdef LC3_MEM_ACV_EN
        .priv(priv), .mem_acv(mem_acv),
`endif
        .from_bus(from_bus), .mar_out(mar_out), .mdr_out(mdr_out), .mem_r(mem_r)
    );

    lc3_mem_responder #(.DEPTH_LOG2(16), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .mem_en(mem_en), .r_w(r_w),
`ifdef LC3_MEM_ACV_EN
        .priv(priv), .mem_acv(d1_mem_acv),
`endif
        .from_bus(from_bus), .mar_out(d1_mar_out), .mdr_out(d1_mdr_out), .mem_r(d1_mem_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_txn(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                           input logic exp_viol, output logic acv_seen);
        int          lat;
        logic [15:0] exp;
        ld_mar = 1'b1; from_bus = addr; step(); ld_mar = 1'b0;
        ld_mdr = 1'b1; mio_en = 1'b0; from_bus = data; step(); ld_mdr = 1'b0;
        mem_en = 1'b1; r_w = rw; step(); mem_en = 1'b0; r_w = 1'b0;
        if (rw) begin
            if (!exp_viol) model[addr] = data;
        end else begin
            sb.push_back(exp_viol ? 16'h0000 : model[addr]);
        end
        lat = 1;
        while (mem_r !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat !== 3) begin
            n_errors++;
            $display("FAIL latency addr=%h: got %0d cycles expected 3", addr, lat);
        end
`ifdef LC3_MEM_ACV_EN
        acv_seen = mem_acv;
`else
        acv_seen = 1'b0;
`endif
        if (!rw) begin
            ld_mdr = 1'b1; mio_en = 1'b1;
        end
        step();
        ld_mdr = 1'b0; mio_en = 1'b0;
        n_checks++;
        if (mem_r !== 1'b0) begin
            n_errors++;
            $display("FAIL pulse_width: mem_r got %b expected 0", mem_r);
        end
        if (!rw) begin
            exp = sb.pop_front();
            n_checks++;
            if (mdr_out !== exp) begin
                n_errors++;
                $display("FAIL read_data addr=%h: got %h expected %h", addr, mdr_out, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks += 3;
        if (mar_out !== 16'h0000) begin n_errors++; $display("FAIL reset_mar: got %h expected 0000", mar_out); end
        if (mdr_out !== 16'h0000) begin n_errors++; $display("FAIL reset_mdr: got %h expected 0000", mdr_out); end
        if (mem_r !== 1'b0)       begin n_errors++; $display("FAIL reset_mem_r: got %b expected 0", mem_r); end
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_read();
        logic acv;
        mem_txn(1'b1, 16'h3000, 16'h1234, 1'b0, acv);
        mem_txn(1'b0, 16'h3000, 16'h0000, 1'b0, acv);
    endtask

    task automatic test_write_readback();
        logic acv;
        mem_txn(1'b1, 16'h3005, 16'hBEEF, 1'b0, acv);
        mem_txn(1'b0, 16'h3005, 16'h0000, 1'b0, acv);
        mem_txn(1'b1, 16'h3006, 16'h5A5A, 1'b0, acv);
        mem_txn(1'b0, 16'h3006, 16'h0000, 1'b0, acv);
        mem_txn(1'b0, 16'h3005, 16'h0000, 1'b0, acv);
    endtask

    task automatic test_drop_mem_en();
        logic exp_r;
        ld_mar = 1'b1; from_bus = 16'h3005; step(); ld_mar = 1'b0;
        mem_en = 1'b1; r_w = 1'b0; step();
        for (int k = 1; k <= 8; k++) begin
            mem_en = (k == 1 || k == 2);
            exp_r  = (k == 3);
            n_checks++;
            if (mem_r !== exp_r) begin
                n_errors++;
                $display("FAIL drop_mem_en cycle %0d: mem_r got %b expected %b", k, mem_r, exp_r);
            end
            step();
        end
        mem_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_r;
        ld_mar = 1'b1; from_bus = 16'h3000; step(); ld_mar = 1'b0;
        mem_en = 1'b1; r_w = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_r = (k == 3 || k == 7);
            n_checks++;
            if (mem_r !== exp_r) begin
                n_errors++;
                $display("FAIL back_to_back cycle %0d: mem_r got %b expected %b", k, mem_r, exp_r);
            end
        end
        mem_en = 1'b0;
        step(); step(); step(); step();
    endtask

    task automatic test_reset_mid_write();
        logic acv;
        mem_txn(1'b1, 16'h3010, 16'h0001, 1'b0, acv);
        ld_mar = 1'b1; from_bus = 16'h3010; step(); ld_mar = 1'b0;
        ld_mdr = 1'b1; mio_en = 1'b0; from_bus = 16'h5555; step(); ld_mdr = 1'b0;
        mem_en = 1'b1; r_w = 1'b1; step(); mem_en = 1'b0; r_w = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks += 3;
        if (mem_r !== 1'b0)       begin n_errors++; $display("FAIL midrst_mem_r: got %b expected 0", mem_r); end
        if (mar_out !== 16'h0000) begin n_errors++; $display("FAIL midrst_mar: got %h expected 0000", mar_out); end
        if (mdr_out !== 16'h0000) begin n_errors++; $display("FAIL midrst_mdr: got %h expected 0000", mdr_out); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (mem_r !== 1'b0) begin n_errors++; $display("FAIL midrst_hold %0d: mem_r got %b expected 0", k, mem_r); end
        end
        reset = 1'b0;
        step();
        mem_txn(1'b0, 16'h3010, 16'h0000, 1'b0, acv);
    endtask

    task automatic test_latency1();
        logic exp_r;
        reset = 1'b1; step(); reset = 1'b0; step();
        ld_mar = 1'b1; from_bus = 16'h3000; step(); ld_mar = 1'b0;
        mem_en = 1'b1; r_w = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_r = (k % 2 == 1);
            n_checks++;
            if (d1_mem_r !== exp_r) begin
                n_errors++;
                $display("FAIL lat1_pattern cycle %0d: mem_r got %b expected %b", k, d1_mem_r, exp_r);
            end
            if (k == 1) begin
                ld_mdr = 1'b1; mio_en = 1'b1;
            end
            if (k == 2) begin
                ld_mdr = 1'b0; mio_en = 1'b0;
                n_checks++;
                if (d1_mdr_out !== 16'h1234) begin
                    n_errors++;
                    $display("FAIL lat1_read_data: got %h expected 1234", d1_mdr_out);
                end
            end
        end
        mem_en = 1'b0;
        reset = 1'b1; step(); reset = 1'b0; step();
    endtask

`ifdef LC3_MEM_ACV_EN
    task automatic test_acv();
        logic acv;
        priv = 1'b0;
        mem_txn(1'b1, 16'h0200, 16'h1111, 1'b0, acv);
        n_checks++;
        if (acv !== 1'b0) begin n_errors++; $display("FAIL acv_priv0_write: got %b expected 0", acv); end
        priv = 1'b1;
        mem_txn(1'b1, 16'h0200, 16'hAAAA, 1'b1, acv);
        n_checks++;
        if (acv !== 1'b1) begin n_errors++; $display("FAIL acv_priv1_write: got %b expected 1", acv); end
        mem_txn(1'b0, 16'h0200, 16'h0000, 1'b1, acv);
        n_checks++;
        if (acv !== 1'b1) begin n_errors++; $display("FAIL acv_priv1_read: got %b expected 1", acv); end
        priv = 1'b0;
        mem_txn(1'b0, 16'h0200, 16'h0000, 1'b0, acv);
        n_checks++;
        if (acv !== 1'b0) begin n_errors++; $display("FAIL acv_priv0_read: got %b expected 0", acv); end
        priv = 1'b1;
        mem_txn(1'b1, 16'h4000, 16'h7777, 1'b0, acv);
        mem_txn(1'b0, 16'h4000, 16'h0000, 1'b0, acv);
        n_checks++;
        if (acv !== 1'b0) begin n_errors++; $display("FAIL acv_user_legal: got %b expected 0", acv); end
        priv = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        ld_mar   = 1'b0;
        ld_mdr   = 1'b0;
        mio_en   = 1'b0;
        mem_en   = 1'b0;
        r_w      = 1'b0;
        from_bus = 16'h0000;
`ifdef LC3_MEM_ACV_EN
        priv     = 1'b0;
`endif
        test_reset();
        test_read();
        test_write_readback();
        test_drop_mem_en();
        test_back_to_back();
        test_reset_mid_write();
        test_latency1();
`ifdef LC3_MEM_ACV_EN
        test_acv();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC-3 datapath. Owns the MAR and MDR registers and a word-addressed RAM.
- Serves read and write requests issued by the control FSM with a fixed access latency, and signals completion with the ready flag R (mem_r).
- Sits at the far end of the fetch/load/store path. It consumes addresses driven onto the bus (PC, adder results) and returns instruction and data words to MDR for the bus and IR.

Parameters:
- DEPTH_LOG2, 16, log2 of RAM depth in 16-bit words. The array is indexed by MAR[DEPTH_LOG2-1:0]; upper bits are ignored (aliasing).
- LATENCY, 3, cycles from request acceptance to mem_r assertion. Legal range 1..15; an elaboration-time error is raised outside this range.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- ld_mar  input  1  load MAR from from_bus
- ld_mdr  input  1  load MDR (source chosen by mio_en)
- mio_en  input  1  MDR source: 0 = from_bus, 1 = RAM read data
- mem_en  input  1  memory request strobe
- r_w  input  1  0 = read, 1 = write (sampled with mem_en)
- from_bus  input  16  global bus value
- mar_out  output  16  current MAR
- mdr_out  output  16  current MDR (drives bus via gate_mdr elsewhere)
- mem_r  output  1  ready: transaction completes this cycle

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values: MAR=0, MDR=0, mem_r=0, FSM=IDLE, latency counter=0, read-data register=0. RAM contents are not reset.
- MAR: on a rising edge with ld_mar=1, MAR <= from_bus. It updates regardless of FSM state.
- MDR: on a rising edge with ld_mdr=1:
  - mio_en=0: MDR <= from_bus.
  - mio_en=1: MDR <= rd_q, the captured read data.
  - ld_mdr with mio_en=1 is only meaningful in the mem_r=1 cycle; at other times it loads the stale rd_q (permitted, not an error).
- FSM states: IDLE, BUSY, READY.
- IDLE:
  - If mem_en=1, accept the request: latch req_addr=MAR, req_data=MDR, req_rw=r_w. The values latched are those present before any same-edge ld_mar/ld_mdr takes effect.
  - If LATENCY==1, go to READY; otherwise load the counter with LATENCY-1 and go to BUSY.
- BUSY: decrement the counter each cycle. When the counter reaches 1, go to READY. mem_en and r_w are ignored while BUSY; dropping mem_en does not abort the transaction.
- READY:
  - mem_r=1 for exactly one cycle.
  - Read: rd_q holds RAM[req_addr] throughout this cycle, so ld_mdr+mio_en in this cycle captures it.
  - Write: RAM[req_addr] <= req_data at the end of this cycle.
  - Always return to IDLE.
- Latency: mem_r rises LATENCY cycles after the accepting edge.
- Back-to-back requests: mem_en still high in IDLE after READY is a new request. There is a minimum gap of 1 IDLE cycle between mem_r pulses.
- Read-after-write to the same address returns the new data when the read is accepted after the write's READY cycle.
- Reset mid-transaction: the FSM returns to IDLE and mem_r drops immediately. A pending write is discarded and the RAM is not modified.
- mem_r is a registered output (a decode of the READY state); it has no combinational path from inputs.

Optional Feature:
- Macro: LC3_MEM_ACV_EN.
- When defined, the block adds input priv (1 = user mode) and output mem_acv (1 bit, reset 0).
- A request accepted with priv=1 and req_addr < 16'h3000 or req_addr >= 16'hFE00 is a violation. For a violation:
  - The FSM still runs the full LATENCY.
  - mem_acv=1 alongside mem_r.
  - A write is suppressed.
  - A read returns rd_q=16'h0000.
- When not defined, neither port exists and all addresses are accessible.

Test Plan:
- Reset, then read: ld_mar with bus=16'h3000, then mem_en=1, r_w=0 with RAM[3000]=16'h1234 preloaded by the bench. Expect mem_r=1 exactly 3 cycles after acceptance; ld_mdr+mio_en in that cycle gives mdr_out=16'h1234.
- Write then read back: MAR=16'h3005, MDR=16'hBEEF (mio_en=0), write request, then read request to the same address. Expect MDR=16'hBEEF after the read; one mem_r pulse per request, separated by at least 1 idle cycle.
- Drop mem_en after the acceptance cycle (LATENCY=3): mem_r still pulses at cycle 3. Raise mem_en again in BUSY: no second transaction starts until IDLE.
- Assert reset 1 cycle into a write to 16'h3010 (old value 16'h0001): mem_r stays 0, RAM[3010] remains 16'h0001, and MAR and MDR read 0.
- LATENCY=1 build: mem_r asserts on the first cycle after acceptance. Holding mem_en high continuously gives mem_r high every other cycle.
- With LC3_MEM_ACV_EN: priv=1, write 16'hAAAA to 16'h0200. Expect mem_acv=1 with mem_r and RAM[0200] unchanged. Repeat with priv=0: the write lands and mem_acv=0.
